// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_pkg;

  // Per-channel qualification state.
  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } deb_state_t;

  localparam string POL_LOW  = "LOW";
  localparam string POL_HIGH = "HIGH";

  // Idle (deasserted) pin level for a given active polarity.
  function automatic logic inactive_level(input string polarity);
    return (polarity == POL_LOW) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, qualification FSM, event and hold pulses.
// Latency: SYNC_STAGES + TIMEOUT cycles from a clean input step to data_out.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
//
// Ports:
//   clk, reset (async, active-high), clear (sync re-init)
//   data_in        raw asynchronous pin
//   data_out       debounced level, pin polarity
//   active         debounced level, 1 = asserted
//   assert_pulse   1 cycle, in the first cycle active is 1
//   deassert_pulse 1 cycle, in the first cycle active is 0
//   hold_pulse     1 cycle, in the HOLD_TIMEOUT-th consecutive active cycle
module debounce_channel
  import debounce_pkg::*;
#(
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 10000,
  parameter int    TIMEOUT_WIDTH = 32,
  parameter int    SYNC_STAGES   = 2,
  parameter int    HOLD_TIMEOUT  = 0,
  parameter int    HOLD_WIDTH    = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic data_in,
  output logic data_out,
  output logic active,
  output logic assert_pulse,
  output logic deassert_pulse,
  output logic hold_pulse
);

  localparam logic INACTIVE = inactive_level(POLARITY);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);

  // Synchroniser: the pin enters at bit 0, s is the last stage.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INACTIVE}};
    end else if (clear) begin
      sync_q <= {SYNC_STAGES{INACTIVE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Qualification FSM: data_out follows s only after TIMEOUT consecutive
  // edges at which s differs from it.
  deb_state_t               state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     out_q, out_d;
  logic                     active_q, active_d;
  logic                     assert_q, deassert_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s != out_q) begin
          cnt_d   = CNT_ONE;
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (s == out_q) begin
          // Glitch ended before qualifying.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          out_d   = s;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign active_q = out_q ^ INACTIVE;
  assign active_d = out_d ^ INACTIVE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_q      <= INACTIVE;
      assert_q   <= 1'b0;
      deassert_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_q      <= INACTIVE;
      assert_q   <= 1'b0;
      deassert_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      // Registered alongside out_q so each pulse coincides with the new level.
      assert_q   <= active_d & ~active_q;
      deassert_q <= ~active_d & active_q;
    end
  end

  assign data_out       = out_q;
  assign active         = active_q;
  assign assert_pulse   = assert_q;
  assign deassert_pulse = deassert_q;

  // Long-hold detection: hcnt tracks consecutive active cycles, saturating
  // so the pulse fires once per assertion.
  if (HOLD_TIMEOUT > 0) begin : g_hold
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(HOLD_TIMEOUT);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);

    logic [HOLD_WIDTH-1:0] hcnt_q, hcnt_d;
    logic                  hold_q, hold_d;

    always_comb begin
      hcnt_d = '0;
      hold_d = 1'b0;
      if (active_d) begin
        if (hcnt_q < HOLD_MAX) begin
          hcnt_d = hcnt_q + HOLD_ONE;
          hold_d = (hcnt_q == HOLD_MAX - HOLD_ONE);
        end else begin
          hcnt_d = hcnt_q;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else if (clear) begin
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        hold_q <= hold_d;
      end
    end

    assign hold_pulse = hold_q;
  end else begin : g_no_hold
    assign hold_pulse = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// WIDTH independent debouncers for board pins (buttons, reset and DIP switches).
// Latency: SYNC_STAGES + TIMEOUT cycles from a clean input step to data_out.
// Backpressure: none; event pulses are single-cycle, all channels in parallel.
//
// Ports:
//   clk, reset (async, active-high), clear (sync re-init, same effect as reset)
//   data_in[WIDTH]        raw asynchronous pins
//   data_out[WIDTH]       debounced levels, pin polarity
//   active[WIDTH]         debounced levels, 1 = asserted
//   assert_pulse[WIDTH]   / deassert_pulse[WIDTH] / hold_pulse[WIDTH] event pulses
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int    WIDTH         = 1,
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 10000,
  parameter int    TIMEOUT_WIDTH = 32,
  parameter int    SYNC_STAGES   = 2,
  parameter int    HOLD_TIMEOUT  = 0,
  parameter int    HOLD_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] active,
  output logic [WIDTH-1:0] assert_pulse,
  output logic [WIDTH-1:0] deassert_pulse,
  output logic [WIDTH-1:0] hold_pulse
);

  if ((POLARITY != POL_LOW) && (POLARITY != POL_HIGH)) begin : g_bad_polarity
    $error("debounce_multi: POLARITY must be \"LOW\" or \"HIGH\"");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("debounce_multi: TIMEOUT must be at least 2");
  end
  if ($clog2(TIMEOUT + 1) > TIMEOUT_WIDTH) begin : g_bad_timeout_width
    $error("debounce_multi: TIMEOUT_WIDTH too narrow for TIMEOUT");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be at least 2");
  end
  if ((HOLD_TIMEOUT > 0) && ($clog2(HOLD_TIMEOUT + 1) > HOLD_WIDTH)) begin : g_bad_hold_width
    $error("debounce_multi: HOLD_WIDTH too narrow for HOLD_TIMEOUT");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .POLARITY      (POLARITY),
      .TIMEOUT       (TIMEOUT),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .HOLD_TIMEOUT  (HOLD_TIMEOUT),
      .HOLD_WIDTH    (HOLD_WIDTH)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear),
      .data_in        (data_in[i]),
      .data_out       (data_out[i]),
      .active         (active[i]),
      .assert_pulse   (assert_pulse[i]),
      .deassert_pulse (deassert_pulse[i]),
      .hold_pulse     (hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: a LOW-polarity and a HIGH-polarity instance fed
// complementary pins, checked each cycle against a run-length reference model.
// Directed scenarios plus a randomized pin/clear soak.
module tb_debounce_multi;

  localparam int W  = 4;
  localparam int TO = 16;
  localparam int SS = 2;
  localparam int HT = 40;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         clear   = 1'b0;
  logic [W-1:0] data_in = '1;
  logic [W-1:0] data_in_hi;
  logic [W-1:0] dout_lo, act_lo, ap_lo, dp_lo, hp_lo;
  logic [W-1:0] dout_hi, act_hi, ap_hi, dp_hi, hp_hi;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign data_in_hi = ~data_in;

  debounce_multi #(
    .WIDTH(W), .POLARITY("LOW"), .TIMEOUT(TO), .TIMEOUT_WIDTH(32),
    .SYNC_STAGES(SS), .HOLD_TIMEOUT(HT), .HOLD_WIDTH(32)
  ) dut_lo (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
    .data_out(dout_lo), .active(act_lo), .assert_pulse(ap_lo),
    .deassert_pulse(dp_lo), .hold_pulse(hp_lo)
  );

  debounce_multi #(
    .WIDTH(W), .POLARITY("HIGH"), .TIMEOUT(TO), .TIMEOUT_WIDTH(32),
    .SYNC_STAGES(SS), .HOLD_TIMEOUT(HT), .HOLD_WIDTH(32)
  ) dut_hi (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in_hi),
    .data_out(dout_hi), .active(act_hi), .assert_pulse(ap_hi),
    .deassert_pulse(dp_hi), .hold_pulse(hp_hi)
  );

  // Reference model, in LOW-polarity pin terms. hist[k] is the pin value
  // captured k+1 edges ago; run counts consecutive edges at which the
  // synchronised pin disagreed with the output; held counts active cycles.
  logic [W-1:0] m_out, m_ap, m_dp, m_hp;
  logic [W-1:0] hist [SS];
  int           run  [W];
  int           held [W];

  always @(posedge clk or posedge reset) begin
    logic [W-1:0] s;
    if (reset || clear) begin
      m_out = '1;
      m_ap  = '0;
      m_dp  = '0;
      m_hp  = '0;
      for (int c = 0; c < W; c++) begin
        run[c]  = 0;
        held[c] = 0;
      end
      for (int k = 0; k < SS; k++) hist[k] = '1;
    end else begin
      s = hist[SS-1];
      for (int c = 0; c < W; c++) begin
        m_ap[c] = 1'b0;
        m_dp[c] = 1'b0;
        m_hp[c] = 1'b0;
        if (s[c] !== m_out[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == TO) begin
            m_out[c] = s[c];
            run[c]   = 0;
            if (s[c] == 1'b0) m_ap[c] = 1'b1;
            else              m_dp[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
        if (m_out[c] == 1'b0) begin
          if (held[c] <= HT) held[c] = held[c] + 1;
          m_hp[c] = (held[c] == HT);
        end else begin
          held[c] = 0;
        end
      end
      for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = data_in;
    end
  end

  wire [39:0] obs   = {dout_lo, act_lo, ap_lo, dp_lo, hp_lo,
                       dout_hi, act_hi, ap_hi, dp_hi, hp_hi};
  wire [39:0] exp_v = {m_out, ~m_out, m_ap, m_dp, m_hp,
                       ~m_out, ~m_out, m_ap, m_dp, m_hp};

  task automatic test_reset();
    data_in = '1;
    clear   = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({dout_lo, act_lo, ap_lo | dp_lo | hp_lo, dout_hi, act_hi} !== {4'hF, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_assert got=%h exp=%h",
               {dout_lo, act_lo, ap_lo | dp_lo | hp_lo, dout_hi, act_hi}, {4'hF, 16'h0});
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      vectors++;
      if ({dout_lo, act_lo, ap_lo | dp_lo | hp_lo, dout_hi, act_hi, ap_hi | dp_hi | hp_hi}
          !== {4'hF, 20'h0}) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i,
                 {dout_lo, act_lo, ap_lo | dp_lo | hp_lo, dout_hi, act_hi, ap_hi | dp_hi | hp_hi},
                 {4'hF, 20'h0});
      end
    end
  endtask

  task automatic test_clean_step();
    int first_ap;
    int ap_cnt;
    first_ap = -1;
    ap_cnt   = 0;
    @(posedge clk); #1 data_in[0] = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 30) data_in[0] = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL step_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (ap_lo[0]) begin
        ap_cnt++;
        if (first_ap < 0) first_ap = i;
      end
      if (i == 18 || i == 19) begin
        vectors++;
        if ({dout_lo[0], ap_lo[0]} !== {1'b0, (i == 18)}) begin
          miscompares++;
          $display("FAIL step_edge cyc=%0d got=%b exp=%b", i, {dout_lo[0], ap_lo[0]}, {1'b0, (i == 18)});
        end
      end
    end
    vectors++;
    if (first_ap != 18 || ap_cnt != 1) begin
      miscompares++;
      $display("FAIL step_latency got first=%0d count=%0d exp first=18 count=1", first_ap, ap_cnt);
    end
  endtask

  task automatic test_glitch();
    int first_ap;
    int ap_cnt;
    first_ap = -1;
    ap_cnt   = 0;
    @(posedge clk); #1 data_in[1] = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      @(posedge clk); #1;
      if (i == 15) data_in[1] = 1'b1;
      if (i == 40) data_in[1] = 1'b0;
      if (i == 56) data_in[1] = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL glitch_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (ap_lo[1]) begin
        ap_cnt++;
        if (first_ap < 0) first_ap = i;
      end
      if (i == 39) begin
        vectors++;
        if (dout_lo[1] !== 1'b1 || ap_cnt != 0) begin
          miscompares++;
          $display("FAIL glitch_15 got dout=%b pulses=%0d exp dout=1 pulses=0", dout_lo[1], ap_cnt);
        end
      end
    end
    vectors++;
    if (first_ap != 58 || ap_cnt != 1) begin
      miscompares++;
      $display("FAIL glitch_16 got first=%0d count=%0d exp first=58 count=1", first_ap, ap_cnt);
    end
  endtask

  task automatic test_bounce();
    int first_ap;
    int ap_cnt;
    first_ap = -1;
    ap_cnt   = 0;
    @(posedge clk); #1 data_in[3] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == 3 || i == 6 || i == 9 || i == 12) data_in[3] = ~data_in[3];
      if (i == 45) data_in[3] = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL bounce_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (ap_lo[3]) begin
        ap_cnt++;
        if (first_ap < 0) first_ap = i;
      end
    end
    vectors++;
    if (first_ap != 30 || ap_cnt != 1) begin
      miscompares++;
      $display("FAIL bounce_train got first=%0d count=%0d exp first=30 count=1", first_ap, ap_cnt);
    end
  endtask

  task automatic test_hold();
    int t_hold [2];
    int hp_cnt;
    hp_cnt    = 0;
    t_hold[0] = -1;
    t_hold[1] = -1;
    @(posedge clk); #1 data_in[2] = 1'b0;
    for (int i = 1; i <= 290; i++) begin
      @(posedge clk); #1;
      if (i == 120) data_in[2] = 1'b1;
      if (i == 160) data_in[2] = 1'b0;
      if (i == 250) data_in[2] = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL hold_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (hp_lo[2]) begin
        if (hp_cnt < 2) t_hold[hp_cnt] = i;
        hp_cnt++;
      end
    end
    vectors++;
    if (hp_cnt != 2 || t_hold[0] != 57 || t_hold[1] != 217) begin
      miscompares++;
      $display("FAIL hold_pulse got count=%0d at %0d,%0d exp count=2 at 57,217",
               hp_cnt, t_hold[0], t_hold[1]);
    end
  endtask

  task automatic test_clear();
    int first_ap;
    int ap_cnt;
    first_ap = -1;
    ap_cnt   = 0;
    @(posedge clk); #1 data_in[0] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == 12) clear = 1'b1;
      if (i == 13) clear = 1'b0;
      if (i == 45) data_in[0] = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL clear_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (ap_lo[0]) begin
        ap_cnt++;
        if (first_ap < 0) first_ap = i;
      end
      if (i == 13) begin
        vectors++;
        if ({dout_lo[0], ap_lo | dp_lo} !== {1'b1, 4'h0}) begin
          miscompares++;
          $display("FAIL clear_now got=%b exp=%b", {dout_lo[0], ap_lo | dp_lo}, {1'b1, 4'h0});
        end
      end
    end
    vectors++;
    if (first_ap != 31 || ap_cnt != 1) begin
      miscompares++;
      $display("FAIL clear_requalify got first=%0d count=%0d exp first=31 count=1", first_ap, ap_cnt);
    end
  endtask

  task automatic test_async_reset();
    int first_ap;
    first_ap = -1;
    @(posedge clk); #1 data_in = '0;
    for (int i = 1; i <= 90; i++) begin
      @(posedge clk); #1;
      if (i == 30) begin
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({dout_lo, act_lo, ap_lo, dp_lo, hp_lo, dout_hi, act_hi} !== {4'hF, 24'h0}) begin
          miscompares++;
          $display("FAIL async_reset got=%h exp=%h",
                   {dout_lo, act_lo, ap_lo, dp_lo, hp_lo, dout_hi, act_hi}, {4'hF, 24'h0});
        end
      end
      if (i == 34) reset = 1'b0;
      if (i == 60) data_in = '1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL async_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i > 30 && ap_lo == 4'hF && first_ap < 0) first_ap = i;
    end
    vectors++;
    if (first_ap != 52) begin
      miscompares++;
      $display("FAIL async_reassert got=%0d exp=52", first_ap);
    end
  endtask

  task automatic test_parallel();
    @(posedge clk); #1 data_in = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 30) data_in = '1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL parallel_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 17 || i == 18 || i == 48) begin
        vectors++;
        if ({ap_lo, dp_lo, ap_hi, dp_hi} !==
            {(i == 18) ? 4'hF : 4'h0, (i == 48) ? 4'hF : 4'h0,
             (i == 18) ? 4'hF : 4'h0, (i == 48) ? 4'hF : 4'h0}) begin
          miscompares++;
          $display("FAIL parallel_pulses cyc=%0d got=%h exp=%h", i, {ap_lo, dp_lo, ap_hi, dp_hi},
                   {(i == 18) ? 4'hF : 4'h0, (i == 48) ? 4'hF : 4'h0,
                    (i == 18) ? 4'hF : 4'h0, (i == 48) ? 4'hF : 4'h0});
        end
      end
    end
  endtask

  task automatic test_random();
    int left [W];
    for (int c = 0; c < W; c++) left[c] = $urandom_range(1, 20);
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < W; c++) begin
        left[c] = left[c] - 1;
        if (left[c] == 0) begin
          data_in[c] = ~data_in[c];
          left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 24);
        end
      end
      clear = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      vectors++;
      if ((ap_lo & dp_lo) !== 4'h0) begin
        miscompares++;
        $display("FAIL random_exclusive cyc=%0d got=%h exp=0", i, ap_lo & dp_lo);
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_hold();
    test_clear();
    test_async_reset();
    test_parallel();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
